data_sram_arb: RTL
==================

# data_sram_arb

Two-port arbiter that shares the single synchronous data SRAM port between the EX stage (load/store path, master 0) and a secondary master (debug/DMA engine, master 1). Each cycle it grants at most one requester, drives the SRAM request lines through a combinational mux, and returns read data one cycle later to the master that issued the read, tracked by a response-owner register. Master 0 has fixed priority. A starvation guard can promote master 1 after a bounded wait.

## Interface
Parameters:
- STARVE_LIMIT, 8, number of consecutive cycles master 1 may be denied before it is promoted (legal 1–255; used only with the guard compiled in)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- m0_req  in  1  EX-stage access request (EX_valid & memory op)
- m0_we  in  4  byte write strobes; 4'b0000 = read
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_gnt  out  1  access accepted this cycle (combinational; EX uses it as ready_go for memory ops)
- m0_rvalid  out  1  read data valid for master 0
- m0_rdata  out  32  read data for master 0
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same widths and meanings for master 1
- data_sram_en  out  1  SRAM enable
- data_sram_we  out  4  SRAM byte write enables
- data_sram_addr  out  32  SRAM address
- data_sram_wdata  out  32  SRAM write data
- data_sram_rdata  in  32  SRAM read data, valid the cycle after the read is enabled

## Operation
- Requests are level: a master holds req, we, addr and wdata stable until it sees gnt. It may not withdraw a request before the grant.
- Arbitration runs every cycle, combinationally, from the current req inputs and the arbiter state:
  - NORMAL: m0_req wins. m1 is granted only when m0_req=0.
  - BOOST (guard only): m1_req wins. m0 is granted only when m1_req=0.
- At most one gnt is high. gnt is 0 whenever reset=1.
- SRAM mux:
  - data_sram_en = m0_gnt | m1_gnt.
  - data_sram_we/addr/wdata are taken from the granted master.
  - When nothing is granted, we=0, and addr and wdata are 0.
- Response tracking:
  - On a granted read (we==0), set resp_pend=1 and resp_owner=granted master at the clock edge. Otherwise set resp_pend=0.
  - mX_rvalid = resp_pend & (resp_owner==X).
  - m0_rdata and m1_rdata are both wired to data_sram_rdata. Only the rvalid signals are gated.
  - Writes produce no rvalid.
- Back-to-back reads from either master are allowed every cycle. The response for the grant in cycle N is always presented in cycle N+1, so responses never overlap.

## Timing
- Grant latency: 0 cycles. gnt is asserted in the same cycle as req when that master wins.
- Read latency: grant in cycle N, rvalid and rdata in cycle N+1 for exactly 1 cycle.
- Write: committed at the edge ending cycle N.
- Reset values: resp_pend=0, resp_owner=0, state=NORMAL, starve_cnt=0. All outputs are 0 during and after reset until the first request.
- Reset mid-read: a grant in cycle N followed by reset in cycle N+1 suppresses rvalid in N+1 and N+2.
- Simultaneous m0_req and m1_req:
  - NORMAL: m0 is granted.
  - BOOST: m1 is granted.
  - The loser keeps its request asserted.

## Configuration
- DATA_SRAM_ARB_STARVE_GUARD_EN defined:
  - An 8-bit starve_cnt increments each cycle that m1_req=1 and m1_gnt=0.
  - It clears when m1_gnt=1 or m1_req=0.
  - When starve_cnt reaches STARVE_LIMIT, the state goes NORMAL→BOOST at the next edge.
  - In BOOST, the cycle m1 is granted returns the state to BOOST→NORMAL and clears starve_cnt.
  - If m1_req drops while in BOOST, the state also returns to NORMAL.
- Not defined:
  - Strict master-0 priority.
  - No counter and no BOOST state.
  - Master 1 may starve indefinitely.

## Test plan
- Lone m0 read: m0_req=1, we=0, addr=0x1000 in cycle 1 → m0_gnt=1 and data_sram_en=1 in cycle 1. With SRAM returning 0xDEADBEEF, m0_rvalid=1 and m0_rdata=0xDEADBEEF in cycle 2. m1_rvalid stays 0.
- Contention: m0 store (we=4'hF, addr=0x20, wdata=0x5A5A5A5A) and m1 read (addr=0x40) both in cycle 1 → cycle 1: m0_gnt=1, m1_gnt=0. Cycle 2, m0 idle: m1_gnt=1. Cycle 3: m1_rvalid=1.
- Interleaved reads: m0 read in cycle 1, m1 read in cycle 2 → m0_rvalid in cycle 2 only, m1_rvalid in cycle 3 only. No cycle has both high.
- Reset mid-read: m1 read granted in cycle 5, reset=1 in cycle 6 → m1_rvalid=0 in cycles 6 and 7. All gnt signals are 0 in cycle 6.
- Starvation (guard on, STARVE_LIMIT=8): m0_req and m1_req held high continuously → m0 granted in cycles 1–8, m1 granted in cycle 9, m0 granted again from cycle 10. With the guard off, m1 is never granted.

Source files
------------

// File: rtl/data_sram_arb.sv
// data_sram_arb: shares one data SRAM port between EX (master 0) and a debug/DMA master (master 1).
// Define DATA_SRAM_ARB_STARVE_GUARD_EN to promote master 1 after STARVE_LIMIT denied cycles.
module data_sram_arb #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [3:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [3:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("STARVE_LIMIT must be 1..255");
    end

    logic boost;
    logic resp_pend;
    logic resp_owner;

`ifdef DATA_SRAM_ARB_STARVE_GUARD_EN
    typedef enum logic {NORMAL, BOOST} state_t;
    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);
    state_t     state, state_nxt;
    logic [7:0] starve_cnt, starve_cnt_nxt;
    logic       m1_denied;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= NORMAL;
            starve_cnt <= 8'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Promote on the edge where the denied count reaches the limit, so m1 wins the very next cycle.
    always_comb begin
        state_nxt      = state;
        m1_denied      = m1_req & ~m1_gnt;
        starve_cnt_nxt = m1_denied ? starve_cnt + 8'd1 : 8'd0;
        if (state == NORMAL && m1_denied && starve_cnt >= LIMIT_M1)
            state_nxt = BOOST;
        else if (state == BOOST && (m1_gnt || !m1_req))
            state_nxt = NORMAL;
    end

    assign boost = (state == BOOST);
`else
    assign boost = 1'b0;
`endif

    assign m0_gnt = ~reset & m0_req & (~boost | ~m1_req);
    assign m1_gnt = ~reset & m1_req & (boost | ~m0_req);

    assign data_sram_en    = m0_gnt | m1_gnt;
    assign data_sram_we    = m0_gnt ? m0_we    : m1_gnt ? m1_we    : 4'd0;
    assign data_sram_addr  = m0_gnt ? m0_addr  : m1_gnt ? m1_addr  : 32'd0;
    assign data_sram_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_pend  <= 1'b0;
            resp_owner <= 1'b0;
        end else begin
            resp_pend <= data_sram_en & (data_sram_we == 4'd0);
            if (data_sram_en && data_sram_we == 4'd0)
                resp_owner <= m1_gnt;
        end
    end

    // Gating with reset kills a response whose read was granted just before reset rose.
    assign m0_rvalid = ~reset & resp_pend & ~resp_owner;
    assign m1_rvalid = ~reset & resp_pend & resp_owner;
    assign m0_rdata  = data_sram_rdata;
    assign m1_rdata  = data_sram_rdata;
endmodule
